// File: rtl/stack_push_seq_if.sv
// Stack write port between the push sequencer and data memory.
// master: mem_wr, mem_addr, mem_wdata out; mem_ack in. slave: mirror.
interface stack_push_seq_if #(
  parameter int ADDR_W = 12
);
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );
endinterface

// File: rtl/stack_push_seq.sv
// Stack-frame push sequencer for CALL and interrupt entry; owns SP.
// Ports: clk, rst (sync, active-high); interrupt, call_req/call_target,
// ret_pc, ccr_in, sp_inc in; mem (write bus, master); freeze, busy,
// call_ack, pc_load, pc_target, ccr_clr, sp_out, stack_ovf out.
// Optional macro INT_PENDING_EN: remember one interrupt raised while busy.
module stack_push_seq #(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] SP_INIT    = 12'hFFF,
  parameter logic [31:0]       INT_VECTOR = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic              call_req,
  input  logic [31:0]       call_target,
  input  logic [31:0]       ret_pc,
  input  logic [2:0]        ccr_in,
  input  logic              sp_inc,
  stack_push_seq_if.master  mem,
  output logic              freeze,
  output logic              busy,
  output logic              call_ack,
  output logic              pc_load,
  output logic [31:0]       pc_target,
  output logic              ccr_clr,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_ovf
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_LO,
    PUSH_HI,
    PUSH_CCR,
    LOAD_PC
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] sp;
  logic [31:0]       ret_q;
  logic [31:0]       tgt_q;
  logic [2:0]        ccr_q;
  logic              is_int;
  logic              int_take;

`ifdef INT_PENDING_EN
  logic int_pend;

  assign int_take = interrupt | int_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_pend <= 1'b0;
    end else if (state != IDLE) begin
      if (interrupt)
        int_pend <= 1'b1;
    end else if (int_take) begin
      int_pend <= 1'b0;
    end
  end
`else
  assign int_take = interrupt;
`endif

  assign mem.mem_addr = sp;
  assign sp_out       = sp;
  assign freeze       = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sp            <= SP_INIT;
      ret_q         <= '0;
      tgt_q         <= '0;
      ccr_q         <= '0;
      is_int        <= 1'b0;
      busy          <= 1'b0;
      call_ack      <= 1'b0;
      pc_load       <= 1'b0;
      pc_target     <= '0;
      ccr_clr       <= 1'b0;
      stack_ovf     <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_wdata <= '0;
    end else begin
      call_ack <= 1'b0;
      pc_load  <= 1'b0;
      ccr_clr  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sp_inc)
            sp <= sp + 1'b1;
          if (int_take || call_req) begin
            ret_q         <= ret_pc;
            ccr_q         <= ccr_in;
            is_int        <= int_take;
            tgt_q         <= int_take ? INT_VECTOR : call_target;
            call_ack      <= !int_take;
            busy          <= 1'b1;
            mem.mem_wr    <= 1'b1;
            mem.mem_wdata <= ret_pc[15:0];
            state         <= PUSH_LO;
          end
        end
        PUSH_LO: begin
          if (mem.mem_ack) begin
            sp            <= sp - 1'b1;
            if (sp == '0)
              stack_ovf   <= 1'b1;
            mem.mem_wdata <= ret_q[31:16];
            state         <= PUSH_HI;
          end
        end
        PUSH_HI: begin
          if (mem.mem_ack) begin
            sp            <= sp - 1'b1;
            if (sp == '0)
              stack_ovf   <= 1'b1;
            if (is_int) begin
              mem.mem_wdata <= {13'b0, ccr_q};
              state         <= PUSH_CCR;
            end else begin
              mem.mem_wr <= 1'b0;
              pc_load    <= 1'b1;
              pc_target  <= tgt_q;
              state      <= LOAD_PC;
            end
          end
        end
        PUSH_CCR: begin
          if (mem.mem_ack) begin
            sp          <= sp - 1'b1;
            if (sp == '0)
              stack_ovf <= 1'b1;
            mem.mem_wr  <= 1'b0;
            pc_load     <= 1'b1;
            pc_target   <= tgt_q;
            ccr_clr     <= is_int;
            state       <= LOAD_PC;
          end
        end
        LOAD_PC: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy       <= 1'b0;
          mem.mem_wr <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_push_seq.sv
// Directed bench for stack_push_seq: INT/CALL frames, stalls, priority,
// SP wrap and mid-sequence reset.
module tb_stack_push_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt;
  logic        call_req;
  logic [31:0] call_target;
  logic [31:0] ret_pc;
  logic [2:0]  ccr_in;
  logic        sp_inc;
  logic        freeze, busy, call_ack, pc_load, ccr_clr, stack_ovf;
  logic [31:0] pc_target;
  logic [11:0] sp_out;

  logic        call_req2;
  logic        freeze2, busy2, call_ack2, pc_load2, ccr_clr2, ovf2;
  logic [31:0] pc_target2;
  logic [11:0] sp_out2;

  int total = 0;
  int bad   = 0;

  stack_push_seq_if #(.ADDR_W(12)) mem ();
  stack_push_seq_if #(.ADDR_W(12)) mem2 ();

  always #5 clk = ~clk;

  stack_push_seq u_dut (
    .clk         (clk),
    .rst         (rst),
    .interrupt   (interrupt),
    .call_req    (call_req),
    .call_target (call_target),
    .ret_pc      (ret_pc),
    .ccr_in      (ccr_in),
    .sp_inc      (sp_inc),
    .mem         (mem.master),
    .freeze      (freeze),
    .busy        (busy),
    .call_ack    (call_ack),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .ccr_clr     (ccr_clr),
    .sp_out      (sp_out),
    .stack_ovf   (stack_ovf)
  );

  stack_push_seq #(.SP_INIT(12'h000)) u_ovf (
    .clk         (clk),
    .rst         (rst),
    .interrupt   (1'b0),
    .call_req    (call_req2),
    .call_target (32'h0000_0100),
    .ret_pc      (32'h0000_0042),
    .ccr_in      (3'b000),
    .sp_inc      (1'b0),
    .mem         (mem2.master),
    .freeze      (freeze2),
    .busy        (busy2),
    .call_ack    (call_ack2),
    .pc_load     (pc_load2),
    .pc_target   (pc_target2),
    .ccr_clr     (ccr_clr2),
    .sp_out      (sp_out2),
    .stack_ovf   (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [11:0] addr,
                        input logic [15:0] data);
    check({tag, " wr"}, 32'(mem.mem_wr), 32'd1);
    check({tag, " addr"}, 32'(mem.mem_addr), 32'(addr));
    check({tag, " data"}, 32'(mem.mem_wdata), 32'(data));
    check({tag, " busy"}, 32'({busy, freeze}), 32'b11);
  endtask

  initial begin
    rst         = 1'b1;
    interrupt   = 1'b0;
    call_req    = 1'b0;
    call_req2   = 1'b0;
    call_target = '0;
    ret_pc      = '0;
    ccr_in      = '0;
    sp_inc      = 1'b0;
    mem.mem_ack  = 1'b1;
    mem2.mem_ack = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst sp", 32'(sp_out), 32'hFFF);
    check("rst addr", 32'(mem.mem_addr), 32'hFFF);
    check("rst wr", 32'(mem.mem_wr), 32'd0);
    check("rst busy", 32'({busy, freeze}), 32'b00);
    check("rst pcl", 32'({pc_load, ccr_clr, call_ack}), 32'b000);
    check("rst tgt", pc_target, 32'h0);
    check("rst data", 32'(mem.mem_wdata), 32'h0);
    check("rst ovf", 32'(stack_ovf), 32'd0);

    // interrupt frame
    interrupt = 1'b1;
    ret_pc    = 32'h0001_0234;
    ccr_in    = 3'b101;
    step();
    interrupt = 1'b0;
    ret_pc    = 32'hDEAD_BEEF;
    chk_wr("int lo", 12'hFFF, 16'h0234);
    check("int ack", 32'(call_ack), 32'd0);
    step();
    chk_wr("int hi", 12'hFFE, 16'h0001);
    step();
    chk_wr("int ccr", 12'hFFD, 16'h0005);
    step();
    check("int pcl", 32'({pc_load, ccr_clr}), 32'b11);
    check("int tgt", pc_target, 32'h0000_0020);
    check("int wr0", 32'(mem.mem_wr), 32'd0);
    check("int frz", 32'(freeze), 32'd1);
    check("int sp", 32'(sp_out), 32'hFFC);
    step();
    check("int idle", 32'({busy, freeze, pc_load, ccr_clr}), 32'b0);

    // CALL frame
    call_req    = 1'b1;
    call_target = 32'h0000_0400;
    ret_pc      = 32'h0000_0011;
    step();
    check("call ack", 32'(call_ack), 32'd1);
    chk_wr("call lo", 12'hFFC, 16'h0011);
    call_req = 1'b0;
    step();
    check("call ack1", 32'(call_ack), 32'd0);
    chk_wr("call hi", 12'hFFB, 16'h0000);
    step();
    check("call pcl", 32'({pc_load, ccr_clr}), 32'b10);
    check("call tgt", pc_target, 32'h0000_0400);
    check("call sp", 32'(sp_out), 32'hFFA);
    step();
    check("call idle", 32'(busy), 32'd0);

    // CALL with stalled PUSH_HI
    call_req    = 1'b1;
    call_target = 32'h0000_0800;
    ret_pc      = 32'h1234_5678;
    step();
    chk_wr("stl lo", 12'hFFA, 16'h5678);
    call_req = 1'b0;
    step();
    mem.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_wr("stl hold", 12'hFF9, 16'h1234);
      check("stl sp", 32'(sp_out), 32'hFF9);
      check("stl pcl", 32'(pc_load), 32'd0);
    end
    mem.mem_ack = 1'b1;
    step();
    check("stl pcl1", 32'(pc_load), 32'd1);
    check("stl tgt", pc_target, 32'h0000_0800);
    check("stl sp1", 32'(sp_out), 32'hFF8);
    step();

    // INT and CALL together: INT first, CALL afterwards
    interrupt   = 1'b1;
    call_req    = 1'b1;
    call_target = 32'h0000_0500;
    ret_pc      = 32'h0000_0AAA;
    ccr_in      = 3'b010;
    step();
    interrupt = 1'b0;
    check("pri ack", 32'(call_ack), 32'd0);
    chk_wr("pri lo", 12'hFF8, 16'h0AAA);
    step();
    step();
    chk_wr("pri ccr", 12'hFF6, 16'h0002);
    step();
    check("pri pcl", 32'({pc_load, ccr_clr, call_ack}), 32'b110);
    step();
    check("pri idle", 32'({busy, call_ack}), 32'b00);
    step();
    check("pri ack2", 32'(call_ack), 32'd1);
    chk_wr("pri call", 12'hFF5, 16'h0AAA);
    call_req = 1'b0;
    step();
    step();
    check("pri tgt", pc_target, 32'h0000_0500);
    check("pri ccr0", 32'(ccr_clr), 32'd0);
    step();
    check("pri sp", 32'(sp_out), 32'hFF3);

    // interrupt while busy
    call_req    = 1'b1;
    call_target = 32'h0000_0600;
    ret_pc      = 32'h0000_0077;
    step();
    call_req = 1'b0;
    step();
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    check("pend pcl", 32'(pc_load), 32'd1);
    step();
    check("pend idle", 32'(busy), 32'd0);
    step();
`ifdef INT_PENDING_EN
    check("pend start", 32'(busy), 32'd1);
    check("pend addr", 32'(mem.mem_addr), 32'hFF1);
    step();
    step();
    step();
    check("pend tgt", pc_target, 32'h0000_0020);
    step();
    sp_inc = 1'b1;
    step();
    step();
    step();
    sp_inc = 1'b0;
    check("pend sp", 32'(sp_out), 32'hFF1);
`else
    check("pend none", 32'({busy, mem.mem_wr}), 32'b00);
    check("pend sp", 32'(sp_out), 32'hFF1);
`endif

    // sp_inc in IDLE and same-edge acceptance; ignored while busy
    sp_inc = 1'b1;
    step();
    check("inc idle", 32'(sp_out), 32'hFF2);
    call_req    = 1'b1;
    call_target = 32'h0000_0700;
    step();
    check("inc acc", 32'(sp_out), 32'hFF3);
    check("inc addr", 32'(mem.mem_addr), 32'hFF3);
    call_req = 1'b0;
    step();
    check("inc busy", 32'(sp_out), 32'hFF2);
    sp_inc = 1'b0;
    step();
    step();
    check("inc end", 32'(sp_out), 32'hFF1);

    // SP wrap below zero on SP_INIT=0 instance
    call_req2 = 1'b1;
    step();
    call_req2 = 1'b0;
    check("ovf a0", 32'(mem2.mem_addr), 32'h000);
    check("ovf pre", 32'(ovf2), 32'd0);
    step();
    check("ovf a1", 32'(mem2.mem_addr), 32'hFFF);
    check("ovf set", 32'(ovf2), 32'd1);
    step();
    step();
    check("ovf hold", 32'(ovf2), 32'd1);
    check("ovf sp", 32'(sp_out2), 32'hFFE);

    // reset in PUSH_HI abandons the frame
    call_req    = 1'b1;
    call_target = 32'h0000_0900;
    step();
    call_req = 1'b0;
    step();
    chk_wr("rmid hi", 12'hFF0, 16'h0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmid busy", 32'({busy, mem.mem_wr, pc_load}), 32'b000);
    check("rmid sp", 32'(sp_out), 32'hFFF);
    check("rmid ovf", 32'(ovf2), 32'd0);
    step();
    check("rmid after", 32'({busy, mem.mem_wr, pc_load}), 32'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_push_seq.md
Name: stack_push_seq

Overview:
- Write-side sequencer for the stack frames that the decode stage unwinds with pop_pc1/pop_pc2/pop_ccr on RET/RTI.
- On an accepted interrupt or CALL it freezes fetch/decode and pushes the return PC, as two 16-bit words, onto the data-memory stack.
- For interrupts it also pushes the CCR, then loads the new PC.
- It owns the stack pointer. The pop logic increments SP through a pulse input.

Parameters:
- ADDR_W, 12, data-memory word address width
- SP_INIT, 12'hFFF, SP value after reset (full-descending; SP points to the next free word)
- INT_VECTOR, 32'h0000_0020, PC loaded on interrupt entry

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- interrupt  in  1  interrupt request, sampled every cycle
- call_req  in  1  CALL request from decode; held by source until call_ack
- call_target  in  32  CALL destination PC
- ret_pc  in  32  return address to push
- ccr_in  in  3  current flags {C,N,Z}
- sp_inc  in  1  one-cycle pulse from pop logic: SP <= SP+1
- mem_ack  in  1  memory accepted the current write
- mem_wr  out  1  write strobe
- mem_addr  out  ADDR_W  write address (= SP)
- mem_wdata  out  16  write data
- freeze  out  1  stall fetch/decode
- busy  out  1  sequence in progress
- call_ack  out  1  one-cycle pulse, CALL accepted
- pc_load  out  1  one-cycle pulse, load pc_target
- pc_target  out  32  new PC
- ccr_clr  out  1  one-cycle pulse at interrupt entry, clears flags
- sp_out  out  ADDR_W  current SP
- stack_ovf  out  1  sticky: SP wrapped below 0

Behaviour:
- Reset, synchronous, wins over everything, including mid-sequence:
  - state = IDLE, SP = SP_INIT.
  - All strobes/pulses = 0; pc_target = 0; mem_wdata = 0; mem_addr = SP_INIT; stack_ovf = 0.
  - Any partial frame is abandoned and no further writes are issued.
- States: IDLE, PUSH_LO, PUSH_HI, PUSH_CCR, LOAD_PC.
- IDLE acceptance:
  - Accept on the edge where interrupt=1, or where call_req=1 and interrupt=0. Interrupt has priority.
  - On acceptance, latch ret_pc, ccr_in, kind (INT/CALL) and target (INT_VECTOR or call_target). Next state = PUSH_LO.
  - CALL acceptance pulses call_ack in the first PUSH_LO cycle. A call_req held while an interrupt is taken is accepted after that sequence returns to IDLE.
- Push states:
  - mem_wr=1, mem_addr=SP.
  - Data: PUSH_LO = ret_pc[15:0]; PUSH_HI = ret_pc[31:16]; PUSH_CCR = {13'b0, ccr}.
  - Outputs are held stable until mem_ack=1 is sampled. On that edge SP <= SP-1 and the state advances.
  - Transitions: PUSH_LO -> PUSH_HI; PUSH_HI -> PUSH_CCR for INT, LOAD_PC for CALL; PUSH_CCR -> LOAD_PC.
  - Order matches the pop order CCR, PC[31:16], PC[15:0].
- LOAD_PC: pc_load=1 and pc_target=latched target for one cycle; ccr_clr=1 if INT. Next state = IDLE.
- freeze = busy = (state != IDLE). Both are registered: high from the cycle after acceptance through the LOAD_PC cycle inclusive.
- Latency with mem_ack tied high, acceptance at edge k: pc_load is high in cycle k+4 (INT) or k+3 (CALL), and freeze drops in cycle k+5 / k+4.
- SP arithmetic is modulo 2^ADDR_W. A decrement from 0 gives all-ones and sets stack_ovf, which holds until reset. An increment from all-ones wraps to 0 with no flag.
- sp_inc is honoured only in IDLE. If sp_inc and a new acceptance fall on the same edge, SP is incremented and the sequence starts. sp_inc while busy is ignored; the pop logic is frozen then.
- interrupt while busy: dropped, unless the optional feature is enabled.

Optional Feature:
- Macro INT_PENDING_EN.
- Defined:
  - A one-deep pending flag sets when interrupt=1 while busy.
  - In IDLE, the flag is treated as interrupt=1, with priority over call_req, and clears on acceptance.
  - rst clears it.
  - Multiple interrupts during one sequence collapse into one.
- Not defined: no flag; an interrupt while busy is lost.

Test Plan:
- rst, then interrupt=1 for 1 cycle with ret_pc=32'h0001_0234, ccr_in=3'b101, mem_ack=1 -> three writes at FFF/FFE/FFD with data 0234/0001/0005; SP=FFC; pc_load with target 0000_0020 and ccr_clr in cycle k+4; freeze high for 4 cycles.
- call_req with call_target=32'h0000_0400, ret_pc=32'h0000_0011 -> call_ack once; writes 0011, 0000; pc_load with target 0400 in cycle k+3; no ccr_clr; SP decremented by 2.
- CALL with mem_ack low 3 cycles on PUSH_HI -> mem_wr/addr/data stable across the stall, SP does not change until ack, then completes.
- interrupt and call_req asserted together and both held -> INT frame first; call_ack only after return to IDLE; second frame starts at SP-3.
- SP_INIT=0, CALL -> second write at FFF, stack_ovf=1 and stays 1; rst mid-PUSH_HI -> next cycle IDLE, SP=SP_INIT, mem_wr=0, no pc_load.
- With INT_PENDING_EN, interrupt pulse during a CALL's PUSH_HI -> INT sequence starts on the edge after LOAD_PC; without the macro -> no second sequence.
